// File: rtl/correlator_pkg.sv
// Shared frame-layout helpers for the coincidence integrator and the UART packetizer.
package correlator_pkg;

  // Words per frame: one per channel, then one per unordered channel pair.
  function automatic int num_words(input int n);
    return n + (n * (n - 1)) / 2;
  endfunction

  // Frame position of pair (i,j), i<j, in lexicographic order after the singles.
  function automatic int pair_index(input int i, input int j, input int n);
    return n + i * n - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  // Width of a word index for an n-channel frame, never narrower than one bit.
  function automatic int index_width(input int n);
    return (num_words(n) > 1) ? $clog2(num_words(n)) : 1;
  endfunction

  localparam int DEFAULT_NUM_INPUTS = 12;
  localparam int INDEX_W            = index_width(DEFAULT_NUM_INPUTS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } rd_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; clear wins over increment. The incremented value is
// exported combinationally so a window-end snapshot can include the last cycle.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count_next
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: hold at all-ones instead of wrapping; clear restarts the window at zero.
  always_comb begin
    count_next = (inc && (count_q != '1)) ? count_q + 1'b1 : count_q;
    count_d    = clr ? '0 : count_next;
  end

  // Count register.
  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/coincidence_integrator.sv
// Counts per-channel pulses and pairwise coincidences over a fixed window, snapshots
// them at window end and streams the snapshot out word by word on valid/ready.
module coincidence_integrator
  import correlator_pkg::*;
#(
  parameter int NUM_INPUTS    = 12,
  parameter int RESOLUTION    = 16,
  parameter int WINDOW_CYCLES = 400000
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_INPUTS-1:0]                pulse,
  output logic                                 integration_pulse,
  output logic [RESOLUTION-1:0]                data_out,
  output logic [index_width(NUM_INPUTS)-1:0]   data_index,
  output logic                                 data_valid,
  input  logic                                 data_ready,
  output logic                                 frame_start,
  output logic                                 overrun
);

  localparam int NUM_WORDS = num_words(NUM_INPUTS);
  localparam int IDX_W     = index_width(NUM_INPUTS);
  localparam int WIN_W     = $clog2(WINDOW_CYCLES);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);

  // ---------------------------------------------------------------- window
  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] win_d;
  logic             terminal;

  assign terminal = (win_q == WIN_LAST);

  // Window counter: 0..WINDOW_CYCLES-1, then wrap.
  always_comb begin
    win_d = terminal ? '0 : win_q + 1'b1;
  end

  // Window counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) win_q <= '0;
    else     win_q <= win_d;
  end

  // ---------------------------------------------------------------- live counters
  logic [NUM_WORDS-1:0]  inc_w;
  logic [RESOLUTION-1:0] snap_w [NUM_WORDS];

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_single
    assign inc_w[gi] = pulse[gi];
    for (genvar gj = gi + 1; gj < NUM_INPUTS; gj++) begin : g_pair
      assign inc_w[pair_index(gi, gj, NUM_INPUTS)] = pulse[gi] & pulse[gj];
    end
  end

  for (genvar gw = 0; gw < NUM_WORDS; gw++) begin : g_cnt
    sat_counter #(.WIDTH(RESOLUTION)) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .inc        (inc_w[gw]),
      .clr        (terminal),
      .count_next (snap_w[gw])
    );
  end

  // ---------------------------------------------------------------- readout
  rd_state_e             state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  valid_q, valid_d;
  logic                  frame_start_q, frame_start_d;
  logic [RESOLUTION-1:0] data_out_q, data_out_d;
  logic [RESOLUTION-1:0] shadow_q [NUM_WORDS];
  logic [RESOLUTION-1:0] shadow_d [NUM_WORDS];
  logic                  snap;
  logic                  accept;
  logic [IDX_W-1:0]      idx_inc;

  // A window end while a frame is still draining drops that window's snapshot.
  assign snap    = terminal && (state_q == ST_IDLE);
  assign accept  = valid_q && data_ready;
  assign idx_inc = idx_q + 1'b1;

  // Shadow bank: loaded only from an idle window end, so it is frozen while streaming.
  always_comb begin
    shadow_d = shadow_q;
    if (snap) shadow_d = snap_w;
  end

  // Shadow bank register.
  // NOTE: the shadow bank is reset like any other state so a first frame never exposes garbage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < NUM_WORDS; w++) shadow_q[w] <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  // Readout FSM next state: the output word is muxed ahead of the edge so data_out is a flop.
  // NOTE: every signal gets its hold value first, so no path through the case infers a latch.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    valid_d       = valid_q;
    frame_start_d = frame_start_q;
    data_out_d    = data_out_q;
    case (state_q)
      ST_IDLE: begin
        if (snap) begin
          state_d       = ST_SEND;
          idx_d         = '0;
          valid_d       = 1'b1;
          frame_start_d = 1'b1;
          data_out_d    = snap_w[0];
        end
      end
      ST_SEND: begin
        if (accept) begin
          frame_start_d = 1'b0;
          if (idx_q == IDX_LAST) begin
            state_d    = ST_IDLE;
            idx_d      = '0;
            valid_d    = 1'b0;
            data_out_d = '0;
          end else begin
            idx_d      = idx_inc;
            data_out_d = shadow_q[idx_inc];
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // Readout FSM and registered output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      valid_q       <= 1'b0;
      frame_start_q <= 1'b0;
      data_out_q    <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      valid_q       <= valid_d;
      frame_start_q <= frame_start_d;
      data_out_q    <= data_out_d;
    end
  end

  assign integration_pulse = terminal;
  assign overrun           = terminal && (state_q == ST_SEND);
  assign data_out          = data_out_q;
  assign data_index        = idx_q;
  assign data_valid        = valid_q;
  assign frame_start       = frame_start_q;

endmodule

// File: tb/tb_coincidence_integrator.sv
// Directed bench for coincidence_integrator with 3 channels, 4-bit counts, 16-cycle window.
module tb_coincidence_integrator;

  localparam int N   = 3;
  localparam int RES = 4;
  localparam int WIN = 16;
  localparam int NW  = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   pulse;
  logic           integration_pulse;
  logic [RES-1:0] data_out;
  logic [2:0]     data_index;
  logic           data_valid;
  logic           data_ready;
  logic           frame_start;
  logic           overrun;

  int n_cmp = 0;
  int n_mis = 0;

  coincidence_integrator #(
    .NUM_INPUTS    (N),
    .RESOLUTION    (RES),
    .WINDOW_CYCLES (WIN)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .pulse             (pulse),
    .integration_pulse (integration_pulse),
    .data_out          (data_out),
    .data_index        (data_index),
    .data_valid        (data_valid),
    .data_ready        (data_ready),
    .frame_start       (frame_start),
    .overrun           (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance negedge by negedge until the window strobe; returns cycles waited.
  task automatic wait_terminal(input string tag, output int n);
    n = 0;
    while (!integration_pulse && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_strobe_seen"}, 32'(integration_pulse), 32'd1);
  endtask

  // Called on the first-word negedge; checks the full frame with ready=1.
  task automatic collect_frame(input string tag, input logic [RES-1:0] exp [NW],
                               input bit clear_pulse_after_first);
    for (int w = 0; w < NW; w++) begin
      check($sformatf("%s_valid%0d", tag, w), 32'(data_valid), 32'd1);
      check($sformatf("%s_idx%0d", tag, w), 32'(data_index), 32'(w));
      check($sformatf("%s_word%0d", tag, w), 32'(data_out), 32'(exp[w]));
      check($sformatf("%s_fs%0d", tag, w), 32'(frame_start), 32'(w == 0));
      @(negedge clk);
      if (clear_pulse_after_first) pulse = '0;
    end
    check({tag, "_valid_end"}, 32'(data_valid), 32'd0);
  endtask

  int n;

  initial begin
    rst        = 1'b1;
    pulse      = '0;
    data_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_idx", 32'(data_index), 32'd0);
    check("rst_strobe", 32'(integration_pulse), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);

    // Idle windows: first strobe 15 cycles after release, zero frame.
    rst = 1'b0;
    wait_terminal("w1", n);
    check("w1_latency", 32'(n), 32'd15);
    check("w1_ovr", 32'(overrun), 32'd0);
    @(negedge clk);
    collect_frame("w1", '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, 1'b0);

    // Channels 0 and 1 together for 5 cycles.
    pulse = 3'b011;
    repeat (5) @(negedge clk);
    pulse = '0;
    wait_terminal("w2", n);
    check("w2_period", 32'(n), 32'd4);
    check("w2_ovr", 32'(overrun), 32'd0);
    @(negedge clk);
    collect_frame("w2", '{4'd5, 4'd5, 4'd0, 4'd5, 4'd0, 4'd0}, 1'b0);

    // All channels every cycle: 10 counts in this partial window, then saturation.
    pulse = 3'b111;
    wait_terminal("w3", n);
    @(negedge clk);
    collect_frame("w3", '{4'd10, 4'd10, 4'd10, 4'd10, 4'd10, 4'd10}, 1'b0);
    wait_terminal("w4", n);
    @(negedge clk);
    collect_frame("w4", '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15}, 1'b0);
    pulse = '0;
    wait_terminal("w5", n);
    @(negedge clk);
    collect_frame("w5", '{4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd6}, 1'b0);

    // Backpressure: 2 pulses on ch0, then ready low for 20 cycles across a window end.
    pulse = 3'b001;
    repeat (2) @(negedge clk);
    pulse = '0;
    wait_terminal("w6", n);
    data_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      check($sformatf("hold_valid%0d", k), 32'(data_valid), 32'd1);
      check($sformatf("hold_idx%0d", k), 32'(data_index), 32'd0);
      check($sformatf("hold_word%0d", k), 32'(data_out), 32'd2);
      check($sformatf("hold_ovr%0d", k), 32'(overrun), 32'(k == 15));
      if (k == 1) pulse = 3'b100;
      if (k == 4) pulse = '0;
      @(negedge clk);
    end
    data_ready = 1'b1;
    for (int w = 0; w < NW; w++) begin
      check($sformatf("drain_idx%0d", w), 32'(data_index), 32'(w));
      check($sformatf("drain_word%0d", w), 32'(data_out), 32'(w == 0 ? 2 : 0));
      if (w == 0) pulse = 3'b010;
      if (w == 2) pulse = '0;
      @(negedge clk);
    end
    check("drain_valid_end", 32'(data_valid), 32'd0);
    wait_terminal("w8", n);
    check("w8_ovr", 32'(overrun), 32'd0);
    @(negedge clk);
    collect_frame("w8", '{4'd0, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0}, 1'b0);

    // Pulse on the terminal cycle counts in that window; the next cycle in the next one.
    wait_terminal("w9", n);
    pulse = 3'b100;
    @(negedge clk);
    pulse = 3'b100;
    collect_frame("w9", '{4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0}, 1'b1);
    wait_terminal("w10", n);
    @(negedge clk);
    collect_frame("w10", '{4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0}, 1'b0);

    // Reset in the middle of a frame.
    wait_terminal("w11", n);
    @(negedge clk);
    pulse = 3'b001;
    for (int w = 0; w < 3; w++) @(negedge clk);
    check("mid_idx3", 32'(data_index), 32'd3);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(data_valid), 32'd0);
    check("mid_rst_idx", 32'(data_index), 32'd0);
    check("mid_rst_data", 32'(data_out), 32'd0);
    @(negedge clk);
    pulse = '0;
    @(negedge clk);
    rst = 1'b0;
    wait_terminal("post_rst", n);
    check("post_rst_latency", 32'(n), 32'd15);
    @(negedge clk);
    collect_frame("post_rst", '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
